control_pipe: RTL and testbench

Registered, handshaked successor to the combinational main-control decoder in the decode stage. Decodes a 6-bit opcode into an extended 11-bit control word and holds it in the ID/EX control register. It honours hazard-unit stall and flush requests and sequences a multi-cycle MUL by back-pressuring fetch/decode. Illegal opcodes produce a defined bubble and error count instead of undefined outputs.

---
 rtl/ctrl_pkg.sv | 41 ++++
 rtl/ctrl_decode.sv | 62 ++++++
 rtl/control_pipe.sv | 117 +++++++++++
 tb/tb_control_pipe.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID/EX control pipeline: opcodes, control-word
// layout, ALU operation encodings and the sequencing FSM states.
package ctrl_pkg;

  localparam int CTRL_W = 11;

  // Opcodes understood by the decoder
  localparam logic [5:0] OP_ADD  = 6'h00;
  localparam logic [5:0] OP_SUB  = 6'h01;
  localparam logic [5:0] OP_MUL  = 6'h02;
  localparam logic [5:0] OP_LDB  = 6'h10;
  localparam logic [5:0] OP_LDW  = 6'h11;
  localparam logic [5:0] OP_STB  = 6'h12;
  localparam logic [5:0] OP_STW  = 6'h13;
  localparam logic [5:0] OP_BEQ  = 6'h30;
  localparam logic [5:0] OP_JUMP = 6'h31;

  // Bit positions of each field inside the control word
  localparam int BIT_REGDST   = 10;
  localparam int BIT_BRANCH   = 9;
  localparam int BIT_MEMREAD  = 8;
  localparam int BIT_MEMTOREG = 7;
  localparam int BIT_MEMWRITE = 6;
  localparam int BIT_ALUSRC   = 5;
  localparam int BIT_REGWRITE = 4;
  localparam int BIT_JUMP     = 3;
  localparam int BIT_MEMBYTE  = 2;
  localparam int ALUOP_HI     = 1;
  localparam int ALUOP_LO     = 0;

  // ALU operation encodings (2'b11 is reserved)
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_MUL = 2'b10;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational main-control decoder: opcode -> control word,
// plus flags for illegal opcodes and multi-cycle multiply.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0]        opcode_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              illegal_o,
  output logic              is_mul_o
);

  // Table decode; anything not listed is flagged illegal with an all-zero word
  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    is_mul_o  = 1'b0;
    case (opcode_i)
      OP_ADD: begin
        ctrl_o[BIT_REGDST]         = 1'b1;
        ctrl_o[BIT_REGWRITE]       = 1'b1;
        ctrl_o[ALUOP_HI:ALUOP_LO]  = ALUOP_ADD;
      end
      OP_SUB: begin
        ctrl_o[BIT_REGDST]         = 1'b1;
        ctrl_o[BIT_REGWRITE]       = 1'b1;
        ctrl_o[ALUOP_HI:ALUOP_LO]  = ALUOP_SUB;
      end
      OP_MUL: begin
        ctrl_o[BIT_REGDST]         = 1'b1;
        ctrl_o[BIT_REGWRITE]       = 1'b1;
        ctrl_o[ALUOP_HI:ALUOP_LO]  = ALUOP_MUL;
        is_mul_o                   = 1'b1;
      end
      OP_LDB, OP_LDW: begin
        ctrl_o[BIT_MEMREAD]        = 1'b1;
        ctrl_o[BIT_MEMTOREG]       = 1'b1;
        ctrl_o[BIT_ALUSRC]         = 1'b1;
        ctrl_o[BIT_REGWRITE]       = 1'b1;
        ctrl_o[BIT_MEMBYTE]        = (opcode_i == OP_LDB);
        ctrl_o[ALUOP_HI:ALUOP_LO]  = ALUOP_ADD;
      end
      OP_STB, OP_STW: begin
        ctrl_o[BIT_MEMWRITE]       = 1'b1;
        ctrl_o[BIT_ALUSRC]         = 1'b1;
        ctrl_o[BIT_MEMBYTE]        = (opcode_i == OP_STB);
        ctrl_o[ALUOP_HI:ALUOP_LO]  = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl_o[BIT_BRANCH]         = 1'b1;
        ctrl_o[ALUOP_HI:ALUOP_LO]  = ALUOP_SUB;
      end
      OP_JUMP: begin
        ctrl_o[BIT_BRANCH]         = 1'b1;
        ctrl_o[BIT_JUMP]           = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_pipe.sv
// ID/EX control register with handshake, hazard stall/flush handling,
// multi-cycle MUL sequencing and a saturating illegal-opcode counter.
module control_pipe
  import ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           opcode,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 out_valid,
  output logic [CTRL_W-1:0]    ctrl,
  output logic                 illegal,
  output logic                 mul_busy,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int         CNT_W      = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);
  // A single-cycle MUL never needs the wait state
  localparam bit         ENTER_WAIT = (MUL_CYCLES > 1);

  logic [CTRL_W-1:0]    dec_ctrl;
  logic                 dec_illegal;
  logic                 dec_is_mul;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CTRL_W-1:0]    ctrl_q;
  logic                 out_valid_q;
  logic                 illegal_q;
  logic [ERR_CNT_W-1:0] err_count_q;
  logic [ERR_CNT_W-1:0] err_count_d;
  logic                 accept;

  ctrl_decode u_decode (
    .opcode_i  (opcode),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal),
    .is_mul_o  (dec_is_mul)
  );

  // Handshake: only an unstalled, unflushed IDLE pipe can take an opcode
  always_comb begin
    in_ready    = (state_q == IDLE) & ~stall & ~flush & ~reset;
    accept      = in_valid & in_ready;
    err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;
  end

  // ID/EX register and MUL sequencer; priority reset > flush > stall > normal
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ctrl_q      <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      err_count_q <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ctrl_q      <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (stall) begin
      // Contents and countdown freeze; the illegal pulse never stretches
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && dec_illegal) begin
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b1;
            err_count_q <= err_count_d;
          end else if (accept) begin
            ctrl_q      <= dec_ctrl;
            out_valid_q <= 1'b1;
            illegal_q   <= 1'b0;
            if (dec_is_mul && ENTER_WAIT) begin
              state_q <= MUL_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end else begin
            ctrl_q      <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
          end
        end
        MUL_WAIT: begin
          ctrl_q      <= '0;
          out_valid_q <= 1'b0;
          illegal_q   <= 1'b0;
          cnt_q       <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ctrl      = ctrl_q;
  assign out_valid = out_valid_q;
  assign illegal   = illegal_q;
  assign mul_busy  = (state_q == MUL_WAIT);
  assign err_count = err_count_q;

endmodule

// File: tb/tb_control_pipe.sv
// Randomized + directed bench for control_pipe. Two instances share the
// stimulus: lane 0 with a 4-cycle MUL and 2-bit error counter, lane 1 with a
// single-cycle MUL and 8-bit error counter. A table-driven model predicts
// every output each cycle.
module tb_control_pipe;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [5:0] opcode;
  logic       stall;
  logic       flush;

  logic        rdy   [2];
  logic        ov    [2];
  logic [10:0] ct    [2];
  logic        ill   [2];
  logic        busy  [2];
  logic [7:0]  errc  [2];

  logic [1:0]  err_small;
  logic [7:0]  err_big;

  control_pipe #(.MUL_CYCLES(4), .ERR_CNT_W(2)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
    .opcode(opcode), .stall(stall), .flush(flush), .out_valid(ov[0]),
    .ctrl(ct[0]), .illegal(ill[0]), .mul_busy(busy[0]), .err_count(err_small)
  );

  control_pipe #(.MUL_CYCLES(1), .ERR_CNT_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
    .opcode(opcode), .stall(stall), .flush(flush), .out_valid(ov[1]),
    .ctrl(ct[1]), .illegal(ill[1]), .mul_busy(busy[1]), .err_count(err_big)
  );

  assign errc[0] = {6'b0, err_small};
  assign errc[1] = err_big;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state per lane
  int          m_wait  [2];
  logic [10:0] m_ctrl  [2];
  logic        m_valid [2];
  logic        m_ill   [2];
  int          m_err   [2];
  int          lane_mul [2] = '{4, 1};
  int          lane_max [2] = '{3, 255};

  logic [5:0] legal_ops [9] = '{6'h00, 6'h01, 6'h02, 6'h10, 6'h11,
                                6'h12, 6'h13, 6'h30, 6'h31};

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode table
  function automatic void ref_decode(input logic [5:0] op,
                                     output logic [10:0] c, output bit legal);
    legal = 1'b1;
    case (op)
      6'h00: c = 11'h410;
      6'h01: c = 11'h411;
      6'h02: c = 11'h412;
      6'h10: c = 11'h1B4;
      6'h11: c = 11'h1B0;
      6'h12: c = 11'h064;
      6'h13: c = 11'h060;
      6'h30: c = 11'h201;
      6'h31: c = 11'h208;
      default: begin c = 11'h000; legal = 1'b0; end
    endcase
  endfunction

  function automatic bit model_ready(input int k);
    return (m_wait[k] == 0) && !stall && !flush && !reset;
  endfunction

  // Advance the model across one rising edge using the current inputs
  task automatic model_edge();
    logic [10:0] c;
    bit          legal;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_wait[k] = 0; m_ctrl[k] = '0; m_valid[k] = 0; m_ill[k] = 0; m_err[k] = 0;
      end else if (flush) begin
        m_wait[k] = 0; m_ctrl[k] = '0; m_valid[k] = 0; m_ill[k] = 0;
      end else if (stall) begin
        m_ill[k] = 0;
      end else if (m_wait[k] > 0) begin
        m_wait[k]--; m_ctrl[k] = '0; m_valid[k] = 0; m_ill[k] = 0;
      end else if (in_valid) begin
        ref_decode(opcode, c, legal);
        if (k == 0) $display("txn op=%02h ctrl=%03h legal=%0d t=%0t", opcode, c, legal, $time);
        if (!legal) begin
          m_ctrl[k] = '0; m_valid[k] = 0; m_ill[k] = 1;
          if (m_err[k] < lane_max[k]) m_err[k]++;
        end else begin
          m_ctrl[k] = c; m_valid[k] = 1; m_ill[k] = 0;
          if (opcode == 6'h02) m_wait[k] = lane_mul[k] - 1;
        end
      end else begin
        m_ctrl[k] = '0; m_valid[k] = 0; m_ill[k] = 0;
      end
    end
  endtask

  // One clock cycle: apply inputs, check handshake, clock, check outputs
  task automatic step(input bit r, input bit v, input logic [5:0] op,
                      input bit s, input bit f);
    reset = r; in_valid = v; opcode = op; stall = s; flush = f;
    #1;
    for (int k = 0; k < 2; k++)
      check_value($sformatf("in_ready[%0d]", k), 32'(rdy[k]), 32'(model_ready(k)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_value($sformatf("ctrl[%0d]", k),      32'(ct[k]),   32'(m_ctrl[k]));
      check_value($sformatf("out_valid[%0d]", k), 32'(ov[k]),   32'(m_valid[k]));
      check_value($sformatf("illegal[%0d]", k),   32'(ill[k]),  32'(m_ill[k]));
      check_value($sformatf("mul_busy[%0d]", k),  32'(busy[k]), 32'(m_wait[k] > 0));
      check_value($sformatf("err_count[%0d]", k), 32'(errc[k]), 32'(m_err[k]));
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 0; m_ctrl[k] = '0; m_valid[k] = 0; m_ill[k] = 0; m_err[k] = 0;
    end
    reset = 1; in_valid = 0; opcode = '0; stall = 0; flush = 0;

    // Reset
    step(1, 0, 6'h00, 0, 0);
    step(1, 1, 6'h00, 0, 0);
    // Back-to-back legal stream
    step(0, 1, 6'h00, 0, 0);
    step(0, 1, 6'h10, 0, 0);
    step(0, 1, 6'h13, 0, 0);
    step(0, 1, 6'h30, 0, 0);
    step(0, 1, 6'h31, 0, 0);
    step(0, 0, 6'h00, 0, 0);
    // MUL followed by an ADD held valid
    step(0, 1, 6'h02, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 6'h00, 0, 0);
    step(0, 0, 6'h00, 0, 0);
    // Illegal opcodes, enough to saturate the 2-bit counter
    for (int i = 0; i < 5; i++) step(0, 1, 6'h3F, 0, 0);
    step(0, 0, 6'h00, 0, 0);
    // LDW then stall for three cycles
    step(0, 1, 6'h11, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 6'h01, 1, 0);
    step(0, 0, 6'h00, 0, 0);
    // Flush in the second MUL_WAIT cycle with a pending opcode
    step(0, 1, 6'h02, 0, 0);
    step(0, 1, 6'h00, 0, 0);
    step(0, 1, 6'h00, 0, 1);
    step(0, 1, 6'h00, 0, 0);
    // Stall during MUL_WAIT freezes the countdown
    step(0, 1, 6'h02, 0, 0);
    step(0, 0, 6'h00, 1, 0);
    step(0, 0, 6'h00, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 6'h01, 0, 0);
    // Reset in the middle of MUL_WAIT
    step(0, 1, 6'h3F, 0, 0);
    step(0, 1, 6'h02, 0, 0);
    step(0, 0, 6'h00, 0, 0);
    step(1, 1, 6'h00, 0, 0);
    step(0, 1, 6'h00, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bit         r, v, s, f;
      logic [5:0] op;
      r = ($urandom_range(99) < 2);
      s = ($urandom_range(99) < 12);
      f = ($urandom_range(99) < 6);
      v = ($urandom_range(99) < 75);
      if ($urandom_range(3) == 0) op = 6'($urandom_range(63));
      else                        op = legal_ops[$urandom_range(8)];
      step(r, v, op, s, f);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
